// File: rtl/n64_send_command.sv
// Purpose: serialises an 8-bit N64 console command MSB first, then the console stop bit, onto an open-drain line.
// Latency: data_oe rises 1 cycle after start is accepted; busy lasts 35*US_CYCLES cycles; done/rx_enable pulse on the next cycle.
// Backpressure: start is only sampled in IDLE; requests while busy or in FINISH are dropped, not queued.
module n64_send_command #(
    parameter int US_CYCLES = 100,
    parameter int CNT_W     = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       data_oe,
    output logic       busy,
    output logic       done,
    output logic       rx_enable
);

    // Terminal counts for the one-, two- and three-quantum phases.
    localparam logic [CNT_W-1:0] Q1_LAST = CNT_W'(US_CYCLES - 1);
    localparam logic [CNT_W-1:0] Q2_LAST = CNT_W'(2 * US_CYCLES - 1);
    localparam logic [CNT_W-1:0] Q3_LAST = CNT_W'(3 * US_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH,
        FINISH
    } state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] low_last;
    logic [CNT_W-1:0] high_last;

    // Phase lengths of the current bit: a 1 is short-low/long-high, a 0 the reverse, always 4 quanta total.
    always_comb begin
        low_last  = Q3_LAST;
        high_last = Q1_LAST;
        if (shreg[7]) begin
            low_last  = Q1_LAST;
            high_last = Q3_LAST;
        end
    end

    // Frame sequencer; every output is registered and changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            cnt       <= '0;
            data_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_enable <= 1'b0;
        end else begin
            done      <= 1'b0;
            rx_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= cmd;
                        idx     <= 3'd7;
                        cnt     <= '0;
                        data_oe <= 1'b1;
                        busy    <= 1'b1;
                        state   <= BIT_LOW;
                    end
                end
                BIT_LOW: begin
                    if (cnt == low_last) begin
                        cnt     <= '0;
                        data_oe <= 1'b0;
                        state   <= BIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (cnt == high_last) begin
                        cnt     <= '0;
                        data_oe <= 1'b1;
                        if (idx == 3'd0) begin
                            state <= STOP_LOW;
                        end else begin
                            idx   <= idx - 3'd1;
                            shreg <= {shreg[6:0], 1'b0};
                            state <= BIT_LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_LOW: begin
                    if (cnt == Q1_LAST) begin
                        cnt     <= '0;
                        data_oe <= 1'b0;
                        state   <= STOP_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_HIGH: begin
                    if (cnt == Q2_LAST) begin
                        cnt       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        rx_enable <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    data_oe <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_send_command.sv
module tb_n64_send_command;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] cmd;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       rx_enable;

    logic       start2;
    logic [7:0] cmd2;
    logic       data_oe2;
    logic       busy2;
    logic       done2;
    logic       rx_enable2;

    int checks = 0;
    int errors = 0;

    n64_send_command #(.US_CYCLES(4), .CNT_W(9)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .data_oe(data_oe), .busy(busy), .done(done), .rx_enable(rx_enable)
    );

    n64_send_command #(.US_CYCLES(100), .CNT_W(9)) dut100 (
        .clk(clk), .reset(reset), .start(start2), .cmd(cmd2),
        .data_oe(data_oe2), .busy(busy2), .done(done2), .rx_enable(rx_enable2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line drive for cycle k (1-based after acceptance) at 4 clk per quantum.
    function automatic logic exp_oe(input logic [7:0] c, input int k);
        int p;
        int q;
        logic b;
        p = k - 1;
        if (k < 1 || k > 140) return 1'b0;
        if (p < 128) begin
            b = c[7 - p / 16];
            q = p % 16;
            return (q < (b ? 4 : 12));
        end
        return ((p - 128) < 4);
    endfunction

    // Caller has start=1 with cmd=c present, so acceptance happens at the next edge.
    // hold: cycles start stays high; chain: re-request on the done cycle (lands in FINISH) and hold it.
    task automatic frame_check(input logic [7:0] c, input int hold, input int ones_exp,
                               input int ncyc, input bit chain, input string tag);
        int oe_bad;
        int ones;
        int busy_cnt;
        int done_cnt;
        int done_pos;
        int rx_cnt;
        int rx_pos;
        oe_bad = 0; ones = 0; busy_cnt = 0;
        done_cnt = 0; done_pos = -1; rx_cnt = 0; rx_pos = -1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (data_oe !== exp_oe(c, k)) oe_bad++;
            if (data_oe === 1'b1) ones++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin done_cnt++; if (done_pos < 0) done_pos = k; end
            if (rx_enable === 1'b1) begin rx_cnt++; if (rx_pos < 0) rx_pos = k; end
            start = (k < hold) ? 1'b1 : 1'b0;
            cmd   = ~c;
            if (chain && k >= 141) begin
                start = 1'b1;
                cmd   = 8'h01;
            end
        end
        chk({tag, " oe_pattern_mismatches"}, oe_bad, 0);
        chk({tag, " oe_high_cycles"}, ones, ones_exp);
        chk({tag, " busy_cycles"}, busy_cnt, 140);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_pos, 141);
        chk({tag, " rx_enable_count"}, rx_cnt, 1);
        chk({tag, " rx_enable_cycle"}, rx_pos, 141);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int runs[$];
        int run;
        reset = 1'b1; start = 1'b0; cmd = 8'h00;
        start2 = 1'b0; cmd2 = 8'h00;
        tick(); tick();
        chk("reset data_oe", int'(data_oe), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rx_enable", int'(rx_enable), 0);

        // start coincident with reset is dropped
        start = 1'b1; cmd = 8'hFF;
        tick();
        reset = 1'b0; start = 1'b0;
        tick(); tick();
        chk("start_with_reset busy", int'(busy), 0);
        chk("start_with_reset data_oe", int'(data_oe), 0);

        // 0x01: seven 0-bits, one 1-bit, stop: 7*12 + 4 + 4 = 92 low cycles
        start = 1'b1; cmd = 8'h01;
        frame_check(8'h01, 1, 92, 150, 1'b0, "cmd01");

        // 0xFF: eight 1-bits plus stop = 36 low cycles
        start = 1'b1; cmd = 8'hFF;
        frame_check(8'hFF, 1, 36, 150, 1'b0, "cmdFF");

        // 0x00 with start held 50 cycles: exactly one frame, 8*12 + 4 = 100 low cycles
        start = 1'b1; cmd = 8'h00;
        frame_check(8'h00, 50, 100, 150, 1'b0, "cmd00_held");

        // reset at cycle 60 of a 0xA5 frame
        start = 1'b1; cmd = 8'hA5;
        for (int k = 1; k <= 60; k++) begin
            tick();
            start = 1'b0;
        end
        chk("A5 mid_frame busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk("mid_reset data_oe", int'(data_oe), 0);
        chk("mid_reset busy", int'(busy), 0);
        reset = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (done === 1'b1 || rx_enable === 1'b1) done_cnt++;
            if (busy === 1'b1 || data_oe === 1'b1) busy_cnt++;
        end
        chk("mid_reset no_done", done_cnt, 0);
        chk("mid_reset stays_idle", busy_cnt, 0);
        // 0xA5 = 1010_0101: four 0-bits (12) + four 1-bits (4) + stop (4) = 68
        start = 1'b1; cmd = 8'hA5;
        frame_check(8'hA5, 1, 68, 150, 1'b0, "cmdA5_after_reset");

        // back-to-back: start raised during FINISH (ignored), still high in IDLE (accepted)
        start = 1'b1; cmd = 8'h01;
        frame_check(8'h01, 1, 92, 142, 1'b1, "b2b_first");
        chk("b2b finish_start_ignored busy", int'(busy), 0);
        chk("b2b finish_start_ignored oe", int'(data_oe), 0);
        frame_check(8'h01, 1, 92, 150, 1'b0, "b2b_second");

        // US_CYCLES=100, cmd=0x01: low runs 300 (0-bit), 100 (1-bit), 100 (stop); busy 3500
        start2 = 1'b1; cmd2 = 8'h01;
        busy_cnt = 0; done_cnt = 0; run = 0;
        for (int k = 1; k <= 3600; k++) begin
            tick();
            start2 = 1'b0;
            if (busy2 === 1'b1) busy_cnt++;
            if (done2 === 1'b1) done_cnt++;
            if (data_oe2 === 1'b1) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
        end
        chk("us100 run_count", runs.size(), 9);
        if (runs.size() == 9) begin
            chk("us100 zero_bit_low", runs[0], 300);
            chk("us100 one_bit_low", runs[7], 100);
            chk("us100 stop_low", runs[8], 100);
        end
        chk("us100 busy_cycles", busy_cnt, 3500);
        chk("us100 done_count", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
